// File: rtl/dram_pkg.sv
// dram_pkg: command and bank-state encodings
// shared by the multi-bank DRAM model.
package dram_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'b000,
        ACT  = 3'b001,
        RD   = 3'b010,
        WR   = 3'b011,
        PRE  = 3'b100,
        PREA = 3'b101
    } cmd_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } bank_state_e;

endpackage

// File: rtl/dram_bank_ctrl.sv
// dram_bank_ctrl: one bank's open/idle state,
// open row and tRCD/tRP down-counter.
module dram_bank_ctrl
    import dram_pkg::*;
#(
    parameter int ROW_W = 6,
    parameter int CNT_W = 1,
    parameter int T_RCD = 2,
    parameter int T_RP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             do_act,
    input  logic             do_pre,
    input  logic [ROW_W-1:0] row,
    output logic             act_ok,
    output logic             rd_wr_ok,
    output logic [ROW_W-1:0] open_row
);

    bank_state_e      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bank state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; counter loads T-1 so the command
    // becomes legal exactly T cycles after acceptance.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        if (do_act) begin
            state_d = ACTIVE;
            row_d   = row;
            cnt_d   = CNT_W'(T_RCD - 1);
        end else if (do_pre && state_q == ACTIVE) begin
            state_d = IDLE;
            cnt_d   = CNT_W'(T_RP - 1);
        end
    end

    assign act_ok   = (state_q == IDLE)   && (cnt_q == '0);
    assign rd_wr_ok = (state_q == ACTIVE) && (cnt_q == '0);
    assign open_row = row_q;

endmodule

// File: rtl/dram_multibank_model.sv
// dram_multibank_model: multi-bank DRAM with timing checks
// and CL read pipeline. Optional err port: DRAM_ERR_EN.
module dram_multibank_model
    import dram_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 6,
    parameter int COL_W     = 5,
    parameter int DATA_W    = 8,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int CL        = 3,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cmd,
    input  logic [BANK_W-1:0] bank,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
`ifdef DRAM_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int TMAX   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W  = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [NUM_BANKS-1:0] act_ok_v, rw_ok_v;
    logic [NUM_BANKS-1:0] act_go, pre_go;
    logic [ROW_W-1:0]     open_row_v [NUM_BANKS];
    logic                 rd_go, wr_go;
    logic [BANK_W-1:0]    bank_i;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [CL-1:0]        vld_q;
    logic [DATA_W-1:0]    dat_q [CL];

    assign bank_i = (NUM_BANKS > 1) ? bank : '0;
    assign addr   = {bank_i, open_row_v[bank_i], col};

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        dram_bank_ctrl #(
            .ROW_W (ROW_W),
            .CNT_W (CNT_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .do_act   (act_go[g]),
            .do_pre   (pre_go[g]),
            .row      (row),
            .act_ok   (act_ok_v[g]),
            .rd_wr_ok (rw_ok_v[g]),
            .open_row (open_row_v[g])
        );
    end

    // Decode and gate each command by the target bank's legality.
    always_comb begin
        act_go = '0;
        pre_go = '0;
        rd_go  = 1'b0;
        wr_go  = 1'b0;
        unique case (1'b1)
            (cmd == ACT):  act_go[bank_i] = act_ok_v[bank_i];
            (cmd == RD):   rd_go = rw_ok_v[bank_i];
            (cmd == WR):   wr_go = rw_ok_v[bank_i];
            (cmd == PRE):  pre_go[bank_i] = 1'b1;
            (cmd == PREA): pre_go = '1;
            default: ;
        endcase
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_go)
            mem[addr] <= wr_data;
    end

    // CL-deep read pipeline; data stages hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < CL; i++)
                dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_go;
            if (rd_go)
                dat_q[0] <= mem[addr];
            for (int i = 1; i < CL; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1])
                    dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rd_valid = vld_q[CL-1];
    assign rd_data  = dat_q[CL-1];

`ifdef DRAM_ERR_EN
    logic rej;
    assign rej = !(cmd == NOP || cmd == PRE || cmd == PREA)
              && !(|act_go || rd_go || wr_go);

    // Registered one-cycle pulse for a dropped command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else
            err <= rej;
    end
`endif

endmodule

// File: tb/tb_dram_multibank_model.sv
// tb_dram_multibank_model: directed table, reset-mid-read
// sequence and random traffic against a timestamp model.
module tb_dram_multibank_model;
    import dram_pkg::*;

    localparam int NB   = 4;
    localparam int RW   = 6;
    localparam int CW   = 5;
    localparam int DW   = 8;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int CLAT = 3;
    localparam int BW   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [BW-1:0] bank = '0;
    logic [RW-1:0] row = '0;
    logic [CW-1:0] col = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
`ifdef DRAM_ERR_EN
    logic          err;
`endif

    dram_multibank_model #(
        .NUM_BANKS (NB),
        .ROW_W     (RW),
        .COL_W     (CW),
        .DATA_W    (DW),
        .T_RCD     (TRCD),
        .T_RP      (TRP),
        .CL        (CLAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .bank     (bank),
        .row      (row),
        .col      (col),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`ifdef DRAM_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: bank open flags, absolute cycle at which the
    // bank next becomes usable, sparse memory, queue of due reads.
    typedef struct {
        int            due;
        bit            known;
        logic [DW-1:0] d;
    } rd_t;

    int            cyc;
    bit            m_act [NB];
    int            m_row [NB];
    int            m_rdy [NB];
    logic [DW-1:0] m_mem [int];
    rd_t           q [$];
    bit            e_v;
    bit            e_dk;
    logic [DW-1:0] e_d;
    bit            e_err;

    function automatic int maddr(input int b, input int r, input int c);
        return (b << (RW + CW)) | (r << CW) | c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 1'b0;
            m_row[i] = 0;
            m_rdy[i] = 0;
        end
        q.delete();
        e_d  = '0;
        e_dk = 1'b1;
        cyc  = 0;
    endtask

    task automatic step(input logic [2:0] c, input int b, input int r,
                        input int cl, input logic [DW-1:0] wd);
        bit  rej;
        rd_t e;
        int  a;
        rej = 1'b0;
        cmd = c;
        bank = BW'(b);
        row = RW'(r);
        col = CW'(cl);
        wr_data = wd;
        case (c)
            3'd0: ;
            3'd1: begin
                if (!m_act[b] && cyc >= m_rdy[b]) begin
                    m_act[b] = 1'b1;
                    m_row[b] = r;
                    m_rdy[b] = cyc + TRCD;
                end else rej = 1'b1;
            end
            3'd2: begin
                if (m_act[b] && cyc >= m_rdy[b]) begin
                    a = maddr(b, m_row[b], cl);
                    e.due = cyc + CLAT;
                    e.known = m_mem.exists(a);
                    e.d = e.known ? m_mem[a] : '0;
                    q.push_back(e);
                end else rej = 1'b1;
            end
            3'd3: begin
                if (m_act[b] && cyc >= m_rdy[b])
                    m_mem[maddr(b, m_row[b], cl)] = wd;
                else rej = 1'b1;
            end
            3'd4: begin
                if (m_act[b]) begin
                    m_act[b] = 1'b0;
                    m_rdy[b] = cyc + TRP;
                end
            end
            3'd5: begin
                for (int i = 0; i < NB; i++) begin
                    if (m_act[i]) begin
                        m_act[i] = 1'b0;
                        m_rdy[i] = cyc + TRP;
                    end
                end
            end
            default: rej = 1'b1;
        endcase
        @(posedge clk);
        #1;
        cyc++;
        e_err = rej;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_v  = 1'b1;
            e_dk = q[0].known;
            e_d  = q[0].d;
            q.delete(0);
        end else begin
            e_v = 1'b0;
        end
        chk("model_rd_valid", rd_valid, e_v);
        if (e_dk)
            chk("model_rd_data", rd_data, e_d);
`ifdef DRAM_ERR_EN
        chk("model_err", err, e_err);
`endif
    endtask

    typedef struct {
        logic [2:0]    c;
        int            b;
        int            r;
        int            cl;
        logic [DW-1:0] wd;
        bit            ev;
        logic [DW-1:0] ed;
        bit            ee;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input logic [2:0] c, input int b,
                                input int r, input int cl,
                                input logic [DW-1:0] wd, input bit ev,
                                input logic [DW-1:0] ed, input bit ee);
        vec_t v;
        v.c = c; v.b = b; v.r = r; v.cl = cl; v.wd = wd;
        v.ev = ev; v.ed = ed; v.ee = ee;
        tbl.push_back(v);
    endfunction

    initial begin
        int seen;
        int k;

        // Row i: command in cycle i; expected outputs in cycle i+1.
        add(ACT,  1, 5, 0, 8'h00, 0, 8'h00, 0);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'h00, 0);
        add(WR,   1, 0, 3, 8'hA5, 0, 8'h00, 0);
        add(RD,   1, 0, 3, 8'h00, 0, 8'h00, 0);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'h00, 0);
        add(NOP,  0, 0, 0, 8'h00, 1, 8'hA5, 0);
        add(ACT,  0, 2, 0, 8'h00, 0, 8'hA5, 0);
        add(WR,   0, 0, 7, 8'h3C, 0, 8'hA5, 1);
        add(WR,   0, 0, 7, 8'h4D, 0, 8'hA5, 0);
        add(PRE,  0, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(ACT,  0, 2, 0, 8'h00, 0, 8'hA5, 1);
        add(ACT,  0, 2, 0, 8'h00, 0, 8'hA5, 0);
        add(WR,   0, 0, 7, 8'h99, 0, 8'hA5, 1);
        add(RD,   0, 0, 7, 8'h00, 0, 8'hA5, 0);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(NOP,  0, 0, 0, 8'h00, 1, 8'h4D, 0);
        add(PRE,  1, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(ACT,  1, 5, 0, 8'h00, 0, 8'h4D, 1);
        add(ACT,  1, 5, 0, 8'h00, 0, 8'h4D, 0);
        add(RD,   3, 0, 0, 8'h00, 0, 8'h4D, 1);
        add(RD,   1, 0, 3, 8'h00, 0, 8'h4D, 0);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'h4D, 0);
        add(NOP,  0, 0, 0, 8'h00, 1, 8'hA5, 0);
        add(ACT,  2, 9, 0, 8'h00, 0, 8'hA5, 0);
        add(PRE,  0, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(ACT,  0, 1, 0, 8'h00, 0, 8'hA5, 0);
        add(WR,   2, 0, 0, 8'h22, 0, 8'hA5, 0);
        add(WR,   0, 0, 0, 8'h11, 0, 8'hA5, 0);
        add(RD,   0, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(RD,   2, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(NOP,  0, 0, 0, 8'h00, 1, 8'h11, 0);
        add(NOP,  0, 0, 0, 8'h00, 1, 8'h22, 0);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'h22, 0);
        add(RD,   1, 0, 3, 8'h00, 0, 8'h22, 0);
        add(PREA, 0, 0, 0, 8'h00, 0, 8'h22, 0);
        add(NOP,  0, 0, 0, 8'h00, 1, 8'hA5, 0);
        add(RD,   1, 0, 3, 8'h00, 0, 8'hA5, 1);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(NOP,  0, 0, 0, 8'h00, 0, 8'hA5, 0);
        add(ACT,  2, 9, 0, 8'h00, 0, 8'hA5, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, 8'h00);
`ifdef DRAM_ERR_EN
        chk("reset_err", err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].c, tbl[i].b, tbl[i].r, tbl[i].cl, tbl[i].wd);
            chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
`ifdef DRAM_ERR_EN
            chk($sformatf("tbl%0d_err", i), err, tbl[i].ee);
`endif
        end

        // Reset asserted with a read in flight.
        step(NOP, 0, 0, 0, 8'h00);
        step(RD, 2, 0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        cmd = NOP;
        #1;
        chk("midrst_valid", rd_valid, 1'b0);
        chk("midrst_data", rd_data, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        seen = 0;
        repeat (CLAT + 1) begin
            step(NOP, 0, 0, 0, 8'h00);
            seen += int'(rd_valid);
        end
        chk("no_inflight_after_reset", seen, 0);
        step(RD, 2, 0, 0, 8'h00);
        seen = int'(rd_valid);
        repeat (CLAT) begin
            step(NOP, 0, 0, 0, 8'h00);
            seen += int'(rd_valid);
        end
        chk("rd_idle_after_reset", seen, 0);
        step(ACT, 2, 9, 0, 8'h00);
        repeat (TRCD - 1) step(NOP, 0, 0, 0, 8'h00);
        step(RD, 2, 0, 0, 8'h00);
        repeat (CLAT - 1) step(NOP, 0, 0, 0, 8'h00);
        chk("post_reset_rd_valid", rd_valid, 1'b1);
        chk("post_reset_rd_data", rd_data, 8'h22);

        // Random traffic on a small address window.
        repeat (800) begin
            k = $urandom_range(0, 99);
            if (k < 20)
                step(ACT, $urandom_range(0, NB-1), $urandom_range(0, 3),
                     0, 8'h00);
            else if (k < 42)
                step(RD, $urandom_range(0, NB-1), 0,
                     $urandom_range(0, 3), 8'h00);
            else if (k < 64)
                step(WR, $urandom_range(0, NB-1), 0,
                     $urandom_range(0, 3), DW'($urandom));
            else if (k < 74)
                step(PRE, $urandom_range(0, NB-1), 0, 0, 8'h00);
            else if (k < 77)
                step(PREA, 0, 0, 0, 8'h00);
            else if (k < 80)
                step(3'($urandom_range(6, 7)), $urandom_range(0, NB-1),
                     0, 0, 8'h00);
            else
                step(NOP, 0, 0, 0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
